phy_tx_lane: RTL and testbench
==============================

Name: phy_tx_lane

Overview:
Single-lane transmit serializer for the PHY transmit path. It accepts 32-bit words over a valid/ready handshake and splits each word into 4 bytes. Each byte is shifted out MSB-first on one serial line, clocked by clk_32f. After reset it sends a COM training sequence. Between words it sends IDLE symbols, so the lane receiver can align and assert its active flag.

Parameters:
WORD_W, 32, input word width; fixed at 4 bytes, other values unsupported.
COM_SYM, 8'hBC, training/alignment symbol.
IDLE_SYM, 8'h7C, fill symbol sent when trained and no data is pending.
COM_COUNT, 4, number of COM symbols sent after reset before data is allowed; range 1..15.

Ports:
clk_32f  in  1  bit clock; all logic on rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
data_in  in  32  word to transmit; data_in[31:24] is sent first.
valid_in  in  1  data_in is valid.
ready_out  out  1  the block can take a word this cycle.
serial_out  out  1  registered serial bit stream.
active  out  1  training complete; data may be sent.

Behaviour:
- Reset values: serial_out=0, ready_out=0, active=0.
  - Internal reset values: state=TRAIN, bit_cnt=0, byte_cnt=0, com_cnt=0, hold_valid=0, shift register=COM_SYM.
- Symbol timing:
  - The 3-bit bit_cnt counts 0..7 and wraps.
  - Each cycle, serial_out <= shift[7-bit_cnt], so bits go out MSB-first.
  - A symbol boundary is the cycle with bit_cnt==7. The next symbol loads on that cycle, so its MSB appears on serial_out the following cycle with no gap.
- Holding register (one word):
  - ready_out = ~hold_valid & active.
  - Transfer happens when valid_in & ready_out; data_in is captured into hold and hold_valid is set.
  - valid_in without ready_out is ignored. The source must keep data_in stable until the transfer.
- States:
  - TRAIN: every symbol is COM_SYM. com_cnt increments at each symbol boundary. When com_cnt reaches COM_COUNT at a boundary, go to IDLE and set active=1 on the next cycle. Training never repeats until reset.
  - IDLE: at a boundary, if hold_valid:
    - load hold[31:24] as the symbol, copy hold to the word register, clear hold_valid, set byte_cnt=1, go to DATA;
    - otherwise load IDLE_SYM.
  - DATA: at a boundary:
    - if byte_cnt is 1..3, load word byte (3-byte_cnt) and increment byte_cnt;
    - when byte_cnt==3 the last byte loads and byte_cnt wraps to 0.
  - Boundary after the last byte: if hold_valid, start the next word back-to-back with no IDLE; otherwise load IDLE_SYM and go to IDLE.
- Latency: a word accepted in cycle t has its first bit on serial_out 1 cycle after the next symbol boundary, i.e. 2..9 cycles after t.
- Throughput: one word per 32 cycles sustained. ready_out reasserts the cycle after hold empties into the word register.
- Simultaneous load and transfer: at the boundary cycle hold_valid is still 1, so ready_out=0. A transfer in the same cycle as the load is impossible by construction.
- Reset mid-word:
  - The partial word and any held word are discarded and serial_out drops to 0 at once.
  - Training restarts from com_cnt=0 when reset deasserts.
- Symbols are not 8b10b encoded. COM/IDLE values can alias data bytes; framing is the receiver's concern.

Optional Feature:
TX_WORD_COUNT_EN:
- Defined: adds output word_count [15:0], reset 0. It increments at the symbol boundary where the last byte of a word is loaded, and wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, no valid_in, COM_COUNT=4: serial_out is 32 cycles of 10111100 repeated, then active=1 and 01111100 (IDLE) symbols follow; ready_out=1 from cycle 33.
- One word 32'hDEADBEEF after training: serial bytes DE, AD, BE, EF MSB-first, then IDLE_SYM; ready_out low from transfer until hold empties.
- Back-to-back words 32'h01020304 and 32'hA5A55A5A held valid: 8 data bytes contiguous with no IDLE between them; ready_out pulses high 1 cycle per word.
- valid_in during TRAIN with data 32'hFFFFFFFF: not accepted (ready_out=0); no FF bytes appear until the word is re-presented after active=1.
- Reset asserted at bit 3 of byte 2 of 32'h12345678: serial_out=0 and active=0 immediately; after release, exactly 4 COM symbols before any data; old word never transmitted.
- TX_WORD_COUNT_EN defined, 3 words sent: word_count reads 3. Force the counter to 16'hFFFF and send one word: reads 0.

Source files
------------

// File: rtl/phy_tx_lane_if.sv
// rtl/phy_tx_lane_if.sv - word handshake into the lane serializer
interface phy_tx_lane_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/phy_tx_lane.sv
// rtl/phy_tx_lane.sv - single-lane word-to-serial transmitter with COM training and IDLE fill
// Optional feature macro: TX_WORD_COUNT_EN (adds word_count output)
module phy_tx_lane #(
    parameter int         WORD_W    = 32,
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDLE_SYM  = 8'h7C,
    parameter int         COM_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    phy_tx_lane_if.slave         tx,
    output logic                 serial_out,
`ifdef TX_WORD_COUNT_EN
    output logic [15:0]          word_count,
`endif
    output logic                 active
);

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        IDLE  = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [3:0] COM_LAST = 4'(COM_COUNT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        w_byte_cnt_nxt;
    logic [3:0]        r_com_cnt;
    logic [3:0]        w_com_cnt_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [WORD_W-1:0] r_hold;
    logic [WORD_W-1:0] r_word;
    logic              r_hold_valid;
    logic              r_serial;
    logic              r_active;
    logic              w_boundary;
    logic              w_ready;
    logic              w_xfer;
    logic              w_load_word;
    logic              w_active_set;
    logic              w_last_byte;
    logic [7:0]        w_word_byte;

    assign w_boundary   = (r_bit_cnt == 3'd7);
    assign w_ready      = ~r_hold_valid & r_active;
    assign w_xfer       = tx.valid_in & w_ready;
    assign tx.ready_out = w_ready;
    assign serial_out   = r_serial;
    assign active       = r_active;

    always_comb begin
        w_word_byte = r_word[7:0];
        case (r_byte_cnt)
            2'd1:    w_word_byte = r_word[23:16];
            2'd2:    w_word_byte = r_word[15:8];
            default: w_word_byte = r_word[7:0];
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state <= TRAIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every decision happens only at a symbol boundary; between boundaries the symbol just shifts.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_com_cnt_nxt  = r_com_cnt;
        w_load_word    = 1'b0;
        w_active_set   = 1'b0;
        w_last_byte    = 1'b0;
        if (w_boundary) begin
            case (r_state)
                TRAIN: begin
                    w_shift_nxt   = COM_SYM;
                    w_com_cnt_nxt = r_com_cnt + 4'd1;
                    if (r_com_cnt == COM_LAST) begin
                        w_shift_nxt  = IDLE_SYM;
                        w_state_nxt  = IDLE;
                        w_active_set = 1'b1;
                    end
                end
                IDLE: begin
                    if (r_hold_valid) begin
                        w_shift_nxt    = r_hold[31:24];
                        w_load_word    = 1'b1;
                        w_byte_cnt_nxt = 2'd1;
                        w_state_nxt    = DATA;
                    end else begin
                        w_shift_nxt = IDLE_SYM;
                    end
                end
                DATA: begin
                    if (r_byte_cnt == 2'd0) begin
                        if (r_hold_valid) begin
                            w_shift_nxt    = r_hold[31:24];
                            w_load_word    = 1'b1;
                            w_byte_cnt_nxt = 2'd1;
                        end else begin
                            w_shift_nxt = IDLE_SYM;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift_nxt    = w_word_byte;
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        w_last_byte    = (r_byte_cnt == 2'd3);
                    end
                end
                default: begin
                    w_state_nxt = TRAIN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_com_cnt    <= 4'd0;
            r_shift      <= COM_SYM;
            r_hold       <= '0;
            r_word       <= '0;
            r_hold_valid <= 1'b0;
            r_serial     <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_com_cnt  <= w_com_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_serial   <= r_shift[3'd7 - r_bit_cnt];
            r_active   <= r_active | w_active_set;
            if (w_load_word) begin
                r_word <= r_hold;
            end
            // Transfer and load never coincide: a load needs hold full, a transfer needs it empty.
            if (w_xfer) begin
                r_hold       <= tx.data_in;
                r_hold_valid <= 1'b1;
            end else if (w_load_word) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

`ifdef TX_WORD_COUNT_EN
    logic [15:0] r_word_count;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_word_count <= 16'd0;
        end else if (w_last_byte) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_phy_tx_lane.sv
// tb/tb_phy_tx_lane.sv - directed-vector bench for phy_tx_lane
module tb_phy_tx_lane;
    logic clk_32f;
    logic reset;
    logic serial_out;
    logic active;
`ifdef TX_WORD_COUNT_EN
    logic [15:0] word_count;
`endif

    int total;
    int bad;
    int edge_n;
    logic [7:0] got [0:15];
    logic       rdy [0:127];
    logic       act [0:127];

    phy_tx_lane_if #(.WORD_W(32)) tx_if ();

    phy_tx_lane dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .tx         (tx_if.slave),
        .serial_out (serial_out),
`ifdef TX_WORD_COUNT_EN
        .word_count (word_count),
`endif
        .active     (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Clock edges since reset release; a symbol boundary is every edge with edge_n % 8 == 0.
    always @(posedge clk_32f or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8 && (edge_n % 8) != p; i++) @(negedge clk_32f);
        total++;
        if ((edge_n % 8) !== p) begin
            bad++;
            $display("FAIL phase_align got=%0d want=%0d", edge_n % 8, p);
        end
    endtask

    task automatic read_syms(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk_32f);
                if (i * 8 + b == drop_at) tx_if.valid_in = 1'b0;
                got[i] = {got[i][6:0], serial_out};
                rdy[i * 8 + b] = tx_if.ready_out;
                act[i * 8 + b] = active;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tx_if.valid_in = 1'b0;
        tx_if.data_in = 32'h0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        total++; if (serial_out !== 1'b0) begin bad++; $display("FAIL rst_serial got=%b want=0", serial_out); end
        total++; if (tx_if.ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", tx_if.ready_out); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", active); end
    endtask

    task automatic test_training;
        tx_if.data_in = 32'hFFFFFFFF;
        tx_if.valid_in = 1'b1;
        reset = 1'b0;
        read_syms(6, 29);
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 8'hBC) begin bad++; $display("FAIL train_com%0d got=%h want=bc", i, got[i]); end
        end
        for (int i = 4; i < 6; i++) begin
            total++; if (got[i] !== 8'h7C) begin bad++; $display("FAIL train_idle%0d got=%h want=7c", i, got[i]); end
        end
        for (int j = 0; j < 31; j++) begin
            total++; if (rdy[j] !== 1'b0 || act[j] !== 1'b0) begin bad++; $display("FAIL train_rdy_act%0d got=%b%b want=00", j, rdy[j], act[j]); end
        end
        total++; if (act[31] !== 1'b1) begin bad++; $display("FAIL train_active_on got=%b want=1", act[31]); end
        total++; if (rdy[31] !== 1'b1) begin bad++; $display("FAIL train_ready_on got=%b want=1", rdy[31]); end
    endtask

    task automatic test_word(input logic [31:0] w);
        wait_phase(2);
        total++; if (tx_if.ready_out !== 1'b1) begin bad++; $display("FAIL word_ready_pre got=%b want=1", tx_if.ready_out); end
        tx_if.data_in = w;
        tx_if.valid_in = 1'b1;
        @(negedge clk_32f);
        tx_if.valid_in = 1'b0;
        for (int i = 0; i < 8 && (edge_n % 8) != 0; i++) begin
            total++; if (tx_if.ready_out !== 1'b0) begin bad++; $display("FAIL word_ready_hold got=%b want=0", tx_if.ready_out); end
            @(negedge clk_32f);
        end
        total++; if (tx_if.ready_out !== 1'b1) begin bad++; $display("FAIL word_ready_back got=%b want=1", tx_if.ready_out); end
        read_syms(5, -1);
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== w[31 - 8 * i -: 8]) begin bad++; $display("FAIL word_byte%0d got=%h want=%h", i, got[i], w[31 - 8 * i -: 8]); end
        end
        total++; if (got[4] !== 8'h7C) begin bad++; $display("FAIL word_tail_idle got=%h want=7c", got[4]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [0:8];
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h7C};
        wait_phase(2);
        tx_if.data_in = 32'h01020304;
        tx_if.valid_in = 1'b1;
        @(negedge clk_32f);
        tx_if.data_in = 32'hA5A55A5A;
        for (int i = 0; i < 8 && (edge_n % 8) != 0; i++) @(negedge clk_32f);
        total++; if (tx_if.ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready_pulse1 got=%b want=1", tx_if.ready_out); end
        read_syms(9, 0);
        for (int i = 0; i < 9; i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        for (int j = 0; j < 31; j++) begin
            total++; if (rdy[j] !== 1'b0) begin bad++; $display("FAIL b2b_ready_low%0d got=%b want=0", j, rdy[j]); end
        end
        total++; if (rdy[31] !== 1'b1) begin bad++; $display("FAIL b2b_ready_pulse2 got=%b want=1", rdy[31]); end
    endtask

    task automatic test_reset_midword;
        wait_phase(2);
        tx_if.data_in = 32'h12345678;
        tx_if.valid_in = 1'b1;
        @(negedge clk_32f);
        tx_if.valid_in = 1'b0;
        for (int i = 0; i < 8 && (edge_n % 8) != 0; i++) @(negedge clk_32f);
        read_syms(2, -1);
        total++; if (got[0] !== 8'h12 || got[1] !== 8'h34) begin bad++; $display("FAIL mid_prefix got=%h%h want=1234", got[0], got[1]); end
        for (int b = 0; b < 4; b++) @(negedge clk_32f);
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL mid_bit3 got=%b want=1", serial_out); end
        reset = 1'b1;
        #1;
        total++; if (serial_out !== 1'b0) begin bad++; $display("FAIL mid_serial_drop got=%b want=0", serial_out); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL mid_active_drop got=%b want=0", active); end
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        read_syms(6, -1);
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 8'hBC) begin bad++; $display("FAIL mid_com%0d got=%h want=bc", i, got[i]); end
        end
        for (int i = 4; i < 6; i++) begin
            total++; if (got[i] !== 8'h7C) begin bad++; $display("FAIL mid_idle%0d got=%h want=7c", i, got[i]); end
        end
        total++; if (act[30] !== 1'b0 || act[31] !== 1'b1) begin bad++; $display("FAIL mid_active_edge got=%b%b want=01", act[30], act[31]); end
    endtask

`ifdef TX_WORD_COUNT_EN
    task automatic test_word_count;
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL wc_reset got=%0d want=0", word_count); end
        test_word(32'h00000001);
        test_word(32'h00000002);
        test_word(32'h00000003);
        total++; if (word_count !== 16'd3) begin bad++; $display("FAIL wc_three got=%0d want=3", word_count); end
        force dut.r_word_count = 16'hFFFF;
        @(negedge clk_32f);
        release dut.r_word_count;
        test_word(32'h00000004);
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL wc_wrap got=%0d want=0", word_count); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_training;
        test_word(32'hDEADBEEF);
        test_word(32'hFFFFFFFF);
        test_back_to_back;
        test_reset_midword;
`ifdef TX_WORD_COUNT_EN
        test_word_count;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
